// File: rtl/din_stream_fifo.sv
// din_stream_fifo: first-word fall-through stream FIFO feeding a downstream register stage
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   flush               synchronous clear; wins over push and pop
//   in_valid/in_ready   upstream handshake, in_data the offered word
//   out_valid/out_ready downstream handshake, out_data the oldest stored word
//   count               number of words currently stored (0..DEPTH)
module din_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  // Handshakes look only at registered occupancy, so a full FIFO never accepts
  // on a same-cycle pop and an empty FIFO never bypasses a push to the output.
  assign in_ready  = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: doc/din_stream_fifo.md
DIN_STREAM_FIFO -- requirements
Module: din_stream_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL be a power of two >= 2.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 Port flush  input  1  synchronous clear of all stored words.
REQ-006 Port in_valid  input  1  upstream word present on in_data.
REQ-007 Port in_ready  output  1  block can accept a word this cycle.
REQ-008 Port in_data  input  WIDTH  upstream word.
REQ-009 Port out_valid  output  1  head word present on out_data.
REQ-010 Port out_ready  input  1  downstream register stage consumes the head word.
REQ-011 Port out_data  output  WIDTH  head word; drives the downstream stage's din.
REQ-012 Port count  output  $clog2(DEPTH+1)  number of words currently stored.

Function
REQ-013 Push SHALL occur on a rising edge when in_valid && in_ready && !flush.
REQ-014 Pop SHALL occur on a rising edge when out_valid && out_ready && !flush.
REQ-015 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on out_ready.
REQ-016 out_valid SHALL equal (count != 0), driven from registered state only.
REQ-017 out_data SHALL show the oldest stored word (first-word fall-through); value is don't-care when out_valid=0.
REQ-018 Latency: a word pushed at edge N SHALL appear on out_data with out_valid=1 after edge N when the block was empty.
REQ-019 Words SHALL leave in exactly the order they entered; no word SHALL be dropped or duplicated.
REQ-020 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 Push and pop on the same edge SHALL leave count unchanged, both pointers advancing.
REQ-022 When full, in_ready=0 and a same-cycle pop SHALL NOT enable a push in that cycle.
REQ-023 When empty, out_valid=0 so out_ready SHALL have no effect; a same-cycle push SHALL NOT bypass to a pop.
REQ-024 count SHALL increment by 1 on push-only, decrement by 1 on pop-only, never exceed DEPTH nor go below 0.
REQ-025 in_valid with in_ready=0 is a stall, not an error; in_data SHALL be ignored that cycle.
REQ-026 flush=1 SHALL, on the next edge, set count=0 and both pointers to 0, overriding any push or pop that cycle.
REQ-027 Storage array contents SHALL NOT require reset; only pointers and count are reset.

Reset
REQ-028 While rst=1 (asynchronously, without a clock edge): count=0, pointers=0, out_valid=0, in_ready=1.
REQ-029 rst asserted mid-transfer SHALL discard all stored words; after deassertion the first push SHALL be the first word output.
REQ-030 First push after rst deassertion SHALL be accepted on the first rising edge where in_valid=1.

Verification
REQ-031 Reset then push 0x11 with out_ready=0 -> after edge: out_valid=1, out_data=0x11, count=1, in_ready=1.
REQ-032 Push 0xA0..0xA3 with out_ready=0 (DEPTH=4) -> count=4, in_ready=0; 5th word 0xA4 held on in_valid is not accepted until one pop occurs.
REQ-033 Full, hold in_valid=1 and out_ready=1 for 8 cycles with incrementing data -> output sequence strictly in order, no gaps or repeats, count stays in 3..4, pointers wrap at least twice.
REQ-034 Store 3 words, then assert flush with in_valid=1 and out_ready=1 -> next edge count=0, out_valid=0, neither the flushed nor the offered word is ever output.
REQ-035 Store 2 words, assert rst between clock edges -> out_valid falls immediately, count=0; after release push 0x5C -> out_data=0x5C.
REQ-036 Random in_valid/out_ready at 50% for 1000 cycles vs scoreboard model -> zero ordering mismatches, count always equals pushes minus pops.
